input_conditioner: RTL

Multi-channel conditioner for asynchronous board inputs such as DIP switches, push buttons and PS/2-style lines. Each channel passes through a synchroniser, optional polarity inversion, a debouncer and an edge detector. A debug step controller on two designated channels drives stall_debug into the CPU: free-run mode, or single/multi-cycle stepping by button press. Sits in the board top level between the SB_IO input buffers and the CPU.

---
 rtl/input_conditioner.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: synchroniser, polarity fix, debouncer and edge
// detector per channel, plus a debug step controller that drives stall_debug.
module input_conditioner #(
  parameter int                  CHANNELS        = 8,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 16384,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW      = '1,
  parameter int                  RUN_CH          = 7,
  parameter int                  STEP_CH         = 0,
  parameter int                  STEP_CYCLES     = 1
) (
  input  logic                CLK_CPU,
  input  logic                resetp,
  input  logic [CHANNELS-1:0] pins_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                stall_debug,
  output logic                step_busy,
  output logic [1:0]          dbg_state_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [BW-1:0] BURST_LAST = BW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RUN   = 2'd2
  } step_state_e;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]       cnt_q  [CHANNELS];
  logic [CW-1:0]       cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] sample;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;

  step_state_e   state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          stall_q, stall_d;
  logic          busy_q, busy_d;

  always_comb begin
    sync_d[0] = pins_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sample = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Any matching sample clears the count; a full run of disagreeing samples loads the level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sample[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sample[i];
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= ACTIVE_LOW;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Step controller state register.
  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      stall_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
    end
  end

  // Run mode overrides everything, including a request seen in the same cycle.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    if (level_q[RUN_CH]) begin
      state_d = ST_RUN;
      burst_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_q[STEP_CH]) begin
            state_d = ST_BURST;
            burst_d = '0;
          end
        end
        ST_BURST: begin
          if (burst_q == BURST_LAST) begin
            state_d = ST_IDLE;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          burst_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they leave the flops directly.
  always_comb begin
    stall_d = 1'b1;
    busy_d  = 1'b0;
    case (state_d)
      ST_BURST: begin
        stall_d = 1'b0;
        busy_d  = 1'b1;
      end
      ST_RUN: begin
        stall_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign level_o     = level_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign stall_debug = stall_q;
  assign step_busy   = busy_q;
  assign dbg_state_o = state_q;

endmodule
